// File: rtl/msg_schedule_ctrl.sv
// msg_schedule_ctrl: SHA-256 message-schedule sequencer; loads 16 words, then
// streams W[0..ROUNDS-1] using a 16-word sliding window.
module msg_schedule_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [5:0]  w_index,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    state_t      state;
    logic [31:0] win [16];
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic [31:0] next_w;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // slot 0 = W[t-16], slot 1 = W[t-15], slot 9 = W[t-7], slot 14 = W[t-2]
    assign next_w   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    assign in_ready = state == LOAD;
    assign w_valid  = state == EMIT;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign w_index  = t;
    assign w_data   = !w_valid ? 32'd0 : (t < 6'd16) ? win[t[3:0]] : next_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            t     <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                        win[15] <= in_data;
                        cnt     <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= EMIT;
                            t     <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (w_ready) begin
                        if (t >= 6'd16) begin
                            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                            win[15] <= next_w;
                        end
                        // t returns to 0 on the last word so it never passes LAST
                        t <= (t == LAST) ? 6'd0 : t + 6'd1;
                        if (t == LAST) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_schedule_ctrl.sv
// tb_msg_schedule_ctrl: scoreboard bench for msg_schedule_ctrl (ROUNDS=64 and
// ROUNDS=17 instances sharing stimulus).
module tb_msg_schedule_ctrl;
    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];

    logic clk = 0, rst_n = 1, start = 0, in_valid = 0, w_ready = 0, sel17 = 0;
    logic [31:0] in_data = 0;
    logic a_in_ready, a_w_valid, a_busy, a_done, b_in_ready, b_w_valid, b_busy, b_done;
    logic [31:0] a_w_data, b_w_data;
    logic [5:0] a_w_index, b_w_index;
    logic o_in_ready, o_w_valid, o_busy, o_done;
    logic [31:0] o_w_data;
    logic [5:0] o_w_index;

    int vectors = 0, miscompares = 0;
    logic [37:0] sb [$];
    logic [31:0] obs [64];

    msg_schedule_ctrl #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .w_valid(a_w_valid), .w_ready(w_ready), .w_data(a_w_data),
        .w_index(a_w_index), .busy(a_busy), .done(a_done));

    msg_schedule_ctrl #(.ROUNDS(17)) dut17 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .w_valid(b_w_valid), .w_ready(w_ready), .w_data(b_w_data),
        .w_index(b_w_index), .busy(b_busy), .done(b_done));

    assign o_in_ready = sel17 ? b_in_ready : a_in_ready;
    assign o_w_valid  = sel17 ? b_w_valid  : a_w_valid;
    assign o_w_data   = sel17 ? b_w_data   : a_w_data;
    assign o_w_index  = sel17 ? b_w_index  : a_w_index;
    assign o_busy     = sel17 ? b_busy     : a_busy;
    assign o_done     = sel17 ? b_done     : a_done;

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t model(input blk_t b);
        sched_t w;
        for (int i = 0; i < 64; i++)
            w[i] = (i < 16) ? b[i] :
                   (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
                   (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w;
    endfunction

    // Enters and leaves at a negedge; leaves the DUT idle with rst_n released.
    task automatic apply_reset(input int cycles);
        rst_n = 0;
        #1;
        vectors++;
        if ({o_in_ready, o_w_valid, o_w_data, o_w_index, o_busy, o_done} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h want 0",
                     {o_in_ready, o_w_valid, o_w_data, o_w_index, o_busy, o_done});
        end
        sb.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            start = 1'b1;
            in_valid = c[0];
            in_data = $urandom;
            w_ready = 1'b1;
            vectors++;
            if ({o_in_ready, o_w_valid, o_w_data, o_w_index, o_busy, o_done} !== 42'd0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h want 0",
                         {o_in_ready, o_w_valid, o_w_data, o_w_index, o_busy, o_done});
            end
        end
        start = 0;
        in_valid = 0;
        w_ready = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if ({o_in_ready, o_busy, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready/busy/done=%b want 000", {o_in_ready, o_busy, o_done});
        end
    endtask

    // Runs one block from an idle negedge; abort_ld/abort_w (>=0) apply reset mid-block.
    task automatic run_block(input blk_t blk, input int rnd, input bit rand_in, input bit rand_out,
                             input bit abuse, input int abort_ld, input int abort_w);
        sched_t m;
        logic [37:0] e;
        logic [31:0] pd;
        logic [5:0] pi;
        bit prev_stall;
        int i, n, cyc;
        m = model(blk);
        start = 1;
        in_valid = abuse;
        in_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 0;
        in_valid = 0;
        vectors++;
        if ({o_in_ready, o_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL start_latency: got in_ready/busy=%b want 11", {o_in_ready, o_busy});
        end
        for (int k = 0; k < rnd; k++) sb.push_back({6'(k), m[k]});
        i = 0;
        while (i < 16) begin
            if (i == abort_ld) begin
                apply_reset(3);
                return;
            end
            vectors++;
            if ({o_in_ready, o_w_valid, o_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL load_state: got in_ready/w_valid/done=%b want 100", {o_in_ready, o_w_valid, o_done});
            end
            start = abuse ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = rand_in ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = in_valid ? blk[i] : $urandom;
            if (in_valid) i++;
            @(negedge clk);
        end
        in_valid = 0;
        start = 0;
        n = 0;
        cyc = 0;
        prev_stall = 0;
        pd = 0;
        pi = 0;
        while (n < rnd) begin
            if (cyc++ > 4000) begin
                miscompares++;
                $display("FAIL emit_timeout: got %0d words want %0d", n, rnd);
                sb.delete();
                break;
            end
            if (abort_w >= 0 && o_w_valid === 1'b1 && int'(o_w_index) == abort_w) begin
                apply_reset(3);
                return;
            end
            vectors++;
            if ({o_w_valid, o_in_ready, o_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL emit_state: got w_valid/in_ready/done=%b want 100", {o_w_valid, o_in_ready, o_done});
            end
            if (prev_stall) begin
                vectors++;
                if ({o_w_index, o_w_data} !== {pi, pd}) begin
                    miscompares++;
                    $display("FAIL stall_stable: got %0d/%h want %0d/%h", o_w_index, o_w_data, pi, pd);
                end
            end
            start = abuse ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = abuse ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data = $urandom;
            w_ready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_ready) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_underflow: got word %0d want none", o_w_index);
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if ({o_w_index, o_w_data} !== e) begin
                        miscompares++;
                        $display("FAIL word: got %0d/%h want %0d/%h", o_w_index, o_w_data, e[37:32], e[31:0]);
                    end
                end
                obs[n] = o_w_data;
                n++;
            end
            prev_stall = !w_ready;
            pd = o_w_data;
            pi = o_w_index;
            @(negedge clk);
        end
        start = 0;
        in_valid = 0;
        w_ready = 0;
        vectors++;
        if ({o_done, o_busy, o_w_valid, o_in_ready} !== 4'b1100) begin
            miscompares++;
            $display("FAIL done_pulse: got done/busy/w_valid/in_ready=%b want 1100",
                     {o_done, o_busy, o_w_valid, o_in_ready});
        end
        @(negedge clk);
        vectors++;
        if ({o_done, o_busy, sb.size() == 0} !== 3'b001) begin
            miscompares++;
            $display("FAIL done_end: got done/busy/sb_empty=%b want 001", {o_done, o_busy, sb.size() == 0});
        end
    endtask

    function automatic blk_t abc_block();
        blk_t b;
        for (int k = 0; k < 16; k++) b[k] = 32'd0;
        b[0] = 32'h61626380;
        b[15] = 32'h00000018;
        return b;
    endfunction

    function automatic blk_t rand_block();
        blk_t b;
        for (int k = 0; k < 16; k++) b[k] = $urandom;
        return b;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        apply_reset(6);
    endtask

    task automatic test_abc();
        logic [31:0] want [6];
        int idx [6];
        want = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6};
        idx = '{0, 15, 16, 17, 18, 19};
        run_block(abc_block(), 64, 0, 0, 0, -1, -1);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (obs[idx[k]] !== want[k]) begin
                miscompares++;
                $display("FAIL abc_w%0d: got %h want %h", idx[k], obs[idx[k]], want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_block(abc_block(), 64, 1, 1, 0, -1, -1);
    endtask

    task automatic test_wrap();
        blk_t b;
        for (int k = 0; k < 16; k++) b[k] = 32'hFFFFFFFF;
        run_block(b, 64, 1, 1, 0, -1, -1);
    endtask

    task automatic test_abuse();
        run_block(rand_block(), 64, 1, 1, 1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_block(rand_block(), 64, 0, 0, 0, -1, -1);
        run_block(rand_block(), 64, 0, 0, 0, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_block(abc_block(), 64, 0, 0, 0, 8, -1);
        run_block(abc_block(), 64, 0, 1, 0, -1, 30);
        run_block(abc_block(), 64, 0, 0, 0, -1, -1);
    endtask

    task automatic test_rounds17();
        sel17 = 1;
        run_block(abc_block(), 17, 0, 0, 0, 8, -1);
        run_block(rand_block(), 17, 0, 1, 0, -1, 10);
        run_block(abc_block(), 17, 0, 0, 0, -1, -1);
        vectors++;
        if (obs[16] !== 32'h61626380) begin
            miscompares++;
            $display("FAIL r17_last: got %h want 61626380", obs[16]);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_wrap();
        test_abuse();
        test_back_to_back();
        test_reset_mid();
        test_rounds17();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/msg_schedule_ctrl.md
Name: msg_schedule_ctrl

Overview:
- Sequences SHA-256 message-schedule expansion for one 512-bit block: accepts 16 input words, then streams W[0..ROUNDS-1] to the compression round engine.
- Keeps a 16-word sliding window of prior words.
- Computes each expanded word as W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] (mod 2^32).
- Sits between the block/padding front end and the round datapath.

Parameters:
- ROUNDS, 64: number of W words emitted per block. Legal range 17..64.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new block; sampled in IDLE only
- in_valid  input  1  input word valid
- in_ready  output  1  controller accepts an input word this cycle
- in_data  input  32  message word; W[0] first
- w_valid  output  1  w_data/w_index valid
- w_ready  input  1  consumer accepts the word
- w_data  output  32  schedule word W[w_index]
- w_index  output  6  round index t
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; window, load count and t cleared to 0. Outputs: in_ready=0, w_valid=0, w_data=0, w_index=0, busy=0, done=0.
- Functions: sigma0(x) = rotr7 ^ rotr18 ^ shr3. sigma1(x) = rotr17 ^ rotr19 ^ shr10. Adds are 32-bit and carries are discarded.
- States: IDLE, LOAD, EMIT, DONE.
- IDLE: start=1 -> LOAD next cycle; load count=0. start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready shifts in_data into window slot 15 and shifts slots left (slot 0 = oldest).
  - After the 16th accepted word -> EMIT with t=0.
  - in_valid low stalls the load with no side effects.
- EMIT:
  - w_valid=1 and w_index=t.
  - t<16: w_data = window[t]; the window does not shift.
  - t>=16: w_data = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0].
  - On w_valid&w_ready with t>=16: the window shifts left and slot 15 takes the new word.
  - Every handshake increments t.
  - w_data and w_index are functions of registers only and stay stable while w_ready=0.
  - Handshake at t=ROUNDS-1 -> DONE.
- DONE: done=1 for exactly one cycle, busy=1, w_valid=0; then -> IDLE.
- Throughput: one word per cycle when w_ready is held high.
- Latency:
  - start to first in_ready: 1 cycle.
  - Last load handshake to first w_valid: 1 cycle.
  - Last emit handshake to done: 1 cycle.
- in_ready=0 outside LOAD. Any in_valid outside LOAD is ignored and the window is unchanged.
- start and in_valid asserted in the same IDLE cycle: the word is not consumed; loading begins next cycle.
- rst_n asserted mid-LOAD or mid-EMIT: immediate return to reset values. The partial block is discarded and no done pulse is produced.
- Back-to-back blocks: start may be asserted in the first IDLE cycle after done.

Test Plan:
- Reset: hold rst_n=0 with start=1 and in_valid=1 toggling -> all outputs 0, state IDLE. Release; first cycle shows in_ready=0 and busy=0.
- "abc" padded block at full rate:
  - Stimulus: load W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1.
  - w_index 0..15 echo the inputs in order.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
  - All 64 words match the software model; done pulses once, 1 cycle after index 63.
- Backpressure: random w_ready (~50%) and random in_valid gaps on the same block -> identical W sequence. w_data/w_index are stable during every stall; no index is skipped or duplicated.
- Wrap/overflow: all input words 0xFFFFFFFF -> each W[t] equals the model value mod 2^32. No X values appear and t never exceeds 63.
- Protocol abuse: start pulsed during LOAD and EMIT, and in_valid during EMIT -> no effect on sequence or counts.
- Reset mid-operation: rst_n low after 8 loaded words, and again at w_index=30 -> outputs return to reset values with no done pulse. The next block then runs correctly. Repeat with ROUNDS=17: the last index is 16 and done follows it.
